// File: rtl/decoder_seq_pkg.sv
// Shared types and helpers for the decoder select sequencer.
// next_code steps a select code by one, wrapping modulo 2**width.
package decoder_seq_pkg;

    localparam int DEFAULT_SEL_W = 3;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    function automatic int next_code(input int code, input logic dir_down, input int width);
        int mask;
        mask = (1 << width) - 1;
        return dir_down ? ((code - 1) & mask) : ((code + 1) & mask);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell counter that wraps after DWELL_CYCLES enabled cycles.
// expire marks the last cycle of each dwell period.
module dwell_timer #(
    parameter int DWELL_CYCLES = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int               CNT_W = $clog2(DWELL_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    assign expire = (count_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= expire ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_select_sequencer.sv
// Drives the 3-to-8 decoder select, stepping through every code with a fixed dwell.
// Supports one-shot/continuous scans, up/down direction, preload and abort.
module decoder_select_sequencer
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W        = DEFAULT_SEL_W,
    parameter int DWELL_CYCLES = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_cont,
    input  logic             dir_down,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    output logic [SEL_W-1:0] s,
    output logic             busy,
    output logic             step_pulse,
    output logic             done
);

    localparam logic [SEL_W:0] SCAN_LEN = {1'b1, {SEL_W{1'b0}}};

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] s_reg, s_next;
    logic [SEL_W:0]   visited_reg, visited_next;
    logic             busy_reg, busy_next;
    logic             step_reg, step_next;
    logic             done_reg, done_next;
    logic             mode_reg, mode_next;
    logic             dir_reg, dir_next;
    logic             expire;

    // Timer is held at zero while idle so each scan starts a fresh dwell.
    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_reg == IDLE),
        .enable(state_reg == SCAN),
        .expire(expire)
    );

    always_comb begin
        state_next   = state_reg;
        s_next       = s_reg;
        visited_next = visited_reg;
        busy_next    = busy_reg;
        step_next    = 1'b0;
        done_next    = 1'b0;
        mode_next    = mode_reg;
        dir_next     = dir_reg;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    s_next = load_val;
                end
                if (start) begin
                    state_next   = SCAN;
                    busy_next    = 1'b1;
                    visited_next = {{SEL_W{1'b0}}, 1'b1};
                    mode_next    = mode_cont;
                    dir_next     = dir_down;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else if (expire) begin
                    if (!mode_reg && (visited_reg == SCAN_LEN)) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        s_next       = SEL_W'(next_code(int'(s_reg), dir_reg, SEL_W));
                        step_next    = 1'b1;
                        // Saturating keeps continuous scans from wrapping the visit count.
                        visited_next = (visited_reg == SCAN_LEN) ? SCAN_LEN : visited_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            s_reg       <= '0;
            visited_reg <= '0;
            busy_reg    <= 1'b0;
            step_reg    <= 1'b0;
            done_reg    <= 1'b0;
            mode_reg    <= 1'b0;
            dir_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            s_reg       <= s_next;
            visited_reg <= visited_next;
            busy_reg    <= busy_next;
            step_reg    <= step_next;
            done_reg    <= done_next;
            mode_reg    <= mode_next;
            dir_reg     <= dir_next;
        end
    end

    assign s          = s_reg;
    assign busy       = busy_reg;
    assign step_pulse = step_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_decoder_select_sequencer.sv
// Directed bench for decoder_select_sequencer with dwell 4 (inst 0) and dwell 1 (inst 1).
// Expected sequences come from a per-cycle model of code, busy, step_pulse and done.
module tb_decoder_select_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, stop_a, mode_a, dir_a, load_a;
    logic [2:0] load_val_a, s_a;
    logic       busy_a, step_a, done_a;
    logic       rst_b, start_b, stop_b, mode_b, dir_b, load_b;
    logic [2:0] load_val_b, s_b;
    logic       busy_b, step_b, done_b;

    int checks   = 0;
    int failures = 0;

    decoder_select_sequencer #(.SEL_W(3), .DWELL_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .stop(stop_a), .mode_cont(mode_a),
        .dir_down(dir_a), .load(load_a), .load_val(load_val_a), .s(s_a),
        .busy(busy_a), .step_pulse(step_a), .done(done_a)
    );

    decoder_select_sequencer #(.SEL_W(3), .DWELL_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .stop(stop_b), .mode_cont(mode_b),
        .dir_down(dir_b), .load(load_b), .load_val(load_val_b), .s(s_b),
        .busy(busy_b), .step_pulse(step_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int inst, input logic st, input logic sp, input logic md,
                         input logic dr, input logic ld, input logic [2:0] lv);
        if (inst == 0) begin
            start_a = st; stop_a = sp; mode_a = md; dir_a = dr; load_a = ld; load_val_a = lv;
        end else begin
            start_b = st; stop_b = sp; mode_b = md; dir_b = dr; load_b = ld; load_val_b = lv;
        end
    endtask

    task automatic observe(input int inst, output logic [2:0] so, output logic bo,
                           output logic sto, output logic dno);
        if (inst == 0) begin
            so = s_a; bo = busy_a; sto = step_a; dno = done_a;
        end else begin
            so = s_b; bo = busy_b; sto = step_b; dno = done_b;
        end
    endtask

    task automatic check_outs(input string tag, input int inst, input int code,
                              input logic eb, input logic es, input logic ed);
        logic [2:0] so;
        logic       bo, sto, dno;
        observe(inst, so, bo, sto, dno);
        check({tag, " s"}, 32'(so), 32'(code));
        check({tag, " busy"}, 32'(bo), 32'(eb));
        check({tag, " step"}, 32'(sto), 32'(es));
        check({tag, " done"}, 32'(dno), 32'(ed));
    endtask

    // Starts a scan and checks every cycle for k=0..n after the start edge.
    task automatic run_scan(input int inst, input int dwell, input logic do_load,
                            input int start_code, input logic dir, input logic cont,
                            input int n, input int inject_k, input int stop_k);
        int   steps, code;
        logic eb, es, ed;
        drive(inst, 1'b1, 1'b0, cont, dir, do_load, 3'(start_code));
        tick();
        drive(inst, 1'b0, 1'b0, cont, dir, 1'b0, 3'd0);
        for (int k = 0; k <= n; k++) begin
            steps = k / dwell;
            if (!cont && steps > 7) steps = 7;
            code = (start_code + (dir ? -steps : steps)) & 7;
            eb   = cont || (k < 8 * dwell);
            es   = (k % dwell == 0) && (k > 0) && eb;
            ed   = !cont && (k == 8 * dwell);
            check_outs($sformatf("i%0d k%0d", inst, k), inst, code, eb, es, ed);
            if (k == inject_k) drive(inst, 1'b1, 1'b0, cont, !dir, 1'b1, 3'd1);
            if (k == inject_k + 1) drive(inst, 1'b0, 1'b0, cont, dir, 1'b0, 3'd0);
            if (k == stop_k) begin
                drive(inst, 1'b0, 1'b1, cont, dir, 1'b0, 3'd0);
                tick();
                drive(inst, 1'b0, 1'b0, cont, dir, 1'b0, 3'd0);
                check_outs($sformatf("i%0d stop", inst), inst, code, 1'b0, 1'b0, 1'b0);
                tick();
                check_outs($sformatf("i%0d after stop", inst), inst, code, 1'b0, 1'b0, 1'b0);
                $display("scan inst=%0d start=%0d dir=%0d cont=%0d stopped at k=%0d s=%0d",
                         inst, start_code, dir, cont, k, code);
                return;
            end
            if (k < n) tick();
        end
        $display("scan inst=%0d start=%0d dir=%0d cont=%0d ran %0d cycles",
                 inst, start_code, dir, cont, n);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        tick();
        check_outs("reset a", 0, 0, 1'b0, 1'b0, 1'b0);
        check_outs("reset b", 1, 0, 1'b0, 1'b0, 1'b0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // One-shot up from 0, then preloaded down scan from 5.
        run_scan(0, 4, 1'b1, 0, 1'b0, 1'b0, 32, -1, -1);
        run_scan(0, 4, 1'b1, 5, 1'b1, 1'b0, 34, -1, -1);

        // Continuous up from 6, stopped while s=2.
        run_scan(0, 4, 1'b1, 6, 1'b0, 1'b1, 100, -1, 17);

        // Reset mid-scan at s=3, then a fresh scan without preload starts from 0.
        run_scan(0, 4, 1'b1, 0, 1'b0, 1'b0, 12, -1, -1);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check_outs("midscan reset", 0, 0, 1'b0, 1'b0, 1'b0);
        $display("reset applied mid-scan inst=0");
        run_scan(0, 4, 1'b0, 0, 1'b0, 1'b0, 32, -1, -1);

        // start/load/dir toggle while busy at s=4 must be ignored.
        run_scan(0, 4, 1'b1, 0, 1'b0, 1'b0, 33, 17, -1);

        // Dwell of one: advance every cycle, then stop coinciding with expiry.
        run_scan(1, 1, 1'b1, 0, 1'b0, 1'b0, 9, -1, -1);
        run_scan(1, 1, 1'b1, 0, 1'b0, 1'b0, 100, -1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
